uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver, successor to the fixed 8N1-style receiver: configurable data width, parity mode (none/even/odd) with checking, 1 or 2 stop bits, and oversampling ratio. Received words are written, with per-word error flags, into an internal first-word-fall-through FIFO read through a valid/ready handshake. It sits between the baud-rate tick generator and the consumer logic (ALU/command interface) on the same clock.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal 5..9.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: legal 1 or 2.
- OVERSAMPLE, 16: i_tick pulses per bit period, even, >= 8.
- FIFO_DEPTH, 4: power of two, >= 2.
- i_clock  in  1  system clock, all logic on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_tick  in  1  oversampling strobe, one clock wide.
- i_rx  in  1  serial line, asynchronous, idle high.
- i_ready  in  1  consumer accepts head word when o_valid is high.
- i_err_clr  in  1  one-cycle pulse, clears o_overrun.
- o_valid  out  1  FIFO not empty.
- o_data  out  DATA_WIDTH  head word; 0 when FIFO empty.
- o_parity_err  out  1  head word parity flag; 0 when empty or PARITY_MODE=0.
- o_frame_err  out  1  head word framing flag; 0 when empty.
- o_overrun  out  1  sticky: a word was dropped because FIFO was full.
- o_count  out  $clog2(FIFO_DEPTH+1)  words stored.
- o_busy  out  1  receiver FSM not in IDLE.

## Operation
- i_rx passes through a 2-flop synchronizer; both flops reset to 1. All sampling uses the synchronized value.
- FSM states: IDLE, START, DATA, PARITY, STOP, PUSH. Tick counter and bit index advance only on clocks with i_tick=1, except IDLE and PUSH which ignore i_tick.
- IDLE: clears counter/index. If armed and sync rx = 0 -> START. Armed is set whenever sync rx = 1 in IDLE; cleared on entry to IDLE after a framing error (no false start on a break/held-low line).
- START: on tick count OVERSAMPLE/2-1: rx = 0 -> DATA, counter to 0; rx = 1 -> IDLE (glitch rejected, nothing pushed).
- DATA: sample at tick count OVERSAMPLE-1, LSB first, DATA_WIDTH bits; after last -> PARITY, or STOP if PARITY_MODE=0.
- PARITY: one sample. Error if XOR(data, parity bit) != 0 (even) or != 1 (odd).
- STOP: STOP_BITS samples; any sample = 0 sets frame error. After last stop sample -> PUSH (no early abort).
- PUSH: one clock; writes {frame_err, parity_err, data} to FIFO -> IDLE.
- FIFO pop when o_valid && i_ready. Push when FIFO full and no pop in same cycle: word dropped, o_overrun set, o_count unchanged. Push and pop in same cycle when full: both happen, no overrun. When empty, a push is not visible until the next cycle (no bypass).
- o_overrun clears on i_err_clr or reset; set wins if a drop coincides with i_err_clr.
- Reset (any time, including mid-frame): FSM -> IDLE, armed = 1, FIFO emptied, all outputs 0; partial frame discarded.

## Timing
- Reset values: o_valid 0, o_data 0, o_parity_err 0, o_frame_err 0, o_overrun 0, o_count 0, o_busy 0.
- Sync latency: 2 clocks from i_rx change to FSM visibility.
- Last stop-bit sample on tick at clock N: PUSH at N+1, o_valid/o_count updated at N+2.
- Pop at clock N (o_valid && i_ready): next head word or empty state visible at N+1.
- o_busy high from the clock after start detection through PUSH inclusive.
- All outputs registered or decoded from registered state only; no combinational path from i_rx, i_tick or i_ready to outputs other than o_data/flags following read pointer.

## Test plan
- Defaults, i_tick every clock, frame 0xA5 with even parity 0, one stop, i_ready=0 -> o_valid high 2 clocks after stop sample, o_data=0xA5, both error flags 0, o_count=1.
- Same frame with parity bit 1 -> o_data=0xA5, o_parity_err=1; PARITY_MODE=2 with parity 1 -> o_parity_err=0.
- STOP_BITS=2, second stop bit 0, line then held low 100 bit-times -> one word with o_frame_err=1, no further words until line returns high and a new start occurs.
- 5 frames 0x01..0x05, i_ready=0, FIFO_DEPTH=4 -> o_count=4, o_overrun=1, reads return 0x01..0x04; i_err_clr -> o_overrun=0.
- Start pulse low for 4 ticks only -> returns to IDLE, o_count=0, o_busy low again.
- i_reset_n low during DATA bit 3 -> all outputs 0 next cycle; following clean frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word-fall-through
// FIFO. Sync active-low reset; frames are {start, data LSB first, [parity], stop(s)}.
//
// Ports:
//   i_clock, i_reset_n      clock and synchronous active-low reset
//   i_tick                  oversampling strobe, OVERSAMPLE per bit period
//   i_rx                    asynchronous serial line, idle high
//   i_ready                 consumer pops the head word while o_valid is high
//   i_err_clr               clears the sticky overrun flag
//   o_valid                 FIFO not empty
//   o_data                  head word (0 when empty)
//   o_parity_err            head word parity flag (0 when empty)
//   o_frame_err             head word framing flag (0 when empty)
//   o_overrun               sticky: a word was dropped on a full FIFO
//   o_count                 number of stored words
//   o_busy                  receiver is inside a frame
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            i_clock,
    input  logic                            i_reset_n,
    input  logic                            i_tick,
    input  logic                            i_rx,
    input  logic                            i_ready,
    input  logic                            i_err_clr,
    output logic                            o_valid,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic                            o_parity_err,
    output logic                            o_frame_err,
    output logic                            o_overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
    output logic                            o_busy
);

    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int IDX_W  = $clog2(DATA_WIDTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_W = DATA_WIDTH + 2;

    localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]  LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic [FCNT_W-1:0] DEPTH_CNT = FCNT_W'(FIFO_DEPTH);
    localparam logic              ODD_PAR   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_PUSH
    } state_e;

    // ---------------- receiver ----------------
    logic [1:0]            sync_q, sync_d;
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  armed_q, armed_d;
    logic                  rx_s;
    logic                  sample;

    assign sync_d = {sync_q[0], i_rx};
    assign rx_s   = sync_q[1];
    // mid-bit sampling point for data, parity and stop bits
    assign sample = i_tick && (cnt_q == FULL_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        armed_d = armed_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                // a line held low after a bad frame must go high before
                // another start edge is accepted
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (i_tick) begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_d   = '0;
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (i_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (sample) begin
                    cnt_d   = '0;
                    perr_d  = (^{shreg_q, rx_s}) ^ ODD_PAR;
                    state_d = S_STOP;
                end else if (i_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (sample) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        state_d = S_PUSH;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (i_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PUSH: begin
                state_d = S_IDLE;
                if (ferr_q) begin
                    armed_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- FIFO ----------------
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic              ovr_q, ovr_d;
    logic              push, pop, full, wr_en, drop;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] head;

    assign push    = (state_q == S_PUSH);
    assign pop     = (count_q != '0) && i_ready;
    assign full    = (count_q == DEPTH_CNT);
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_en   = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign wr_word = {ferr_q, perr_q, shreg_q};

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        if (wr_en) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + FCNT_W'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - FCNT_W'(1);
        end
        if (drop) begin
            ovr_d = 1'b1;
        end else if (i_err_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    // storage needs no reset: reads are masked by o_valid
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wr_word;
        end
    end

    assign head         = mem_q[rptr_q];
    assign o_valid      = (count_q != '0);
    assign o_data       = o_valid ? head[DATA_WIDTH-1:0] : '0;
    assign o_parity_err = o_valid && head[DATA_WIDTH];
    assign o_frame_err  = o_valid && head[DATA_WIDTH+1];
    assign o_overrun    = ovr_q;
    assign o_count      = count_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo.
// dut: default build; dut2: odd parity, two stop bits.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       rx, rx2;
    logic       ready, ready2;
    logic       err_clr;

    logic       valid, perr, ferr, ovr, busy;
    logic [7:0] data;
    logic [2:0] count;
    logic       valid2, perr2, ferr2, ovr2, busy2;
    logic [7:0] data2;
    logic [2:0] count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .i_clock      (clk),
        .i_reset_n    (reset_n),
        .i_tick       (tick),
        .i_rx         (rx),
        .i_ready      (ready),
        .i_err_clr    (err_clr),
        .o_valid      (valid),
        .o_data       (data),
        .o_parity_err (perr),
        .o_frame_err  (ferr),
        .o_overrun    (ovr),
        .o_count      (count),
        .o_busy       (busy)
    );

    uart_rx_fifo #(
        .PARITY_MODE (2),
        .STOP_BITS   (2)
    ) dut2 (
        .i_clock      (clk),
        .i_reset_n    (reset_n),
        .i_tick       (tick),
        .i_rx         (rx2),
        .i_ready      (ready2),
        .i_err_clr    (err_clr),
        .o_valid      (valid2),
        .o_data       (data2),
        .o_parity_err (perr2),
        .o_frame_err  (ferr2),
        .o_overrun    (ovr2),
        .o_count      (count2),
        .o_busy       (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_bit(input int sel, input logic b);
        if (sel == 0) rx = b;
        else rx2 = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send(input int sel, input logic [7:0] d,
                        input logic par, input logic [1:0] stops);
        put_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) put_bit(sel, d[i]);
        put_bit(sel, par);
        put_bit(sel, stops[0]);
        if (sel != 0) put_bit(sel, stops[1]);
    endtask

    task automatic pop(input int sel);
        if (sel == 0) ready = 1'b1;
        else ready2 = 1'b1;
        @(negedge clk);
        ready  = 1'b0;
        ready2 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        tick    = 1'b1;
        rx      = 1'b1;
        rx2     = 1'b1;
        ready   = 1'b0;
        ready2  = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // clean 0xA5, even parity bit 0
        send(0, 8'hA5, 1'b0, 2'b11);
        repeat (2) @(negedge clk);
        chk("a5_valid", valid, 1);
        chk("a5_data", data, 8'hA5);
        chk("a5_perr", perr, 0);
        chk("a5_ferr", ferr, 0);
        chk("a5_count", count, 1);
        chk("a5_busy", busy, 0);
        pop(0);
        chk("a5_pop_valid", valid, 0);
        chk("a5_pop_data", data, 0);

        // wrong even parity
        send(0, 8'hA5, 1'b1, 2'b11);
        repeat (2) @(negedge clk);
        chk("pe_data", data, 8'hA5);
        chk("pe_perr", perr, 1);
        pop(0);
        chk("pe_pop_perr", perr, 0);

        // odd parity, correct bit 1
        send(1, 8'hA5, 1'b1, 2'b11);
        repeat (2) @(negedge clk);
        chk("odd_data", data2, 8'hA5);
        chk("odd_perr", perr2, 0);
        chk("odd_ferr", ferr2, 0);
        pop(1);
        chk("odd_pop_count", count2, 0);

        // second stop bit low, line held low 100 bit times
        send(1, 8'h33, 1'b1, 2'b01);
        repeat (1600) @(negedge clk);
        chk("brk_count", count2, 1);
        chk("brk_data", data2, 8'h33);
        chk("brk_ferr", ferr2, 1);
        chk("brk_perr", perr2, 0);
        chk("brk_busy", busy2, 0);
        rx2 = 1'b1;
        repeat (32) @(negedge clk);
        chk("brk_idle_count", count2, 1);
        send(1, 8'h5A, 1'b1, 2'b11);
        repeat (2) @(negedge clk);
        chk("brk_next_count", count2, 2);
        pop(1);
        chk("brk_next_data", data2, 8'h5A);
        chk("brk_next_ferr", ferr2, 0);
        pop(1);

        // overrun: five frames into a depth-4 FIFO
        send(0, 8'h01, 1'b1, 2'b11);
        send(0, 8'h02, 1'b1, 2'b11);
        send(0, 8'h03, 1'b0, 2'b11);
        send(0, 8'h04, 1'b1, 2'b11);
        chk("ov_pre", ovr, 0);
        send(0, 8'h05, 1'b0, 2'b11);
        repeat (2) @(negedge clk);
        chk("ov_count", count, 4);
        chk("ov_flag", ovr, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ov_rd%0d", i), data, i);
            pop(0);
        end
        chk("ov_empty", valid, 0);
        chk("ov_sticky", ovr, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ov_clr", ovr, 0);

        // short start glitch
        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("gl_busy_hi", busy, 1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("gl_busy_lo", busy, 0);
        chk("gl_count", count, 0);

        // reset mid-frame with a word already stored
        send(0, 8'h77, 1'b0, 2'b11);
        repeat (2) @(negedge clk);
        chk("mr_pre_count", count, 1);
        put_bit(0, 1'b0);
        put_bit(0, 1'b1);
        put_bit(0, 1'b1);
        put_bit(0, 1'b1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mr_valid", valid, 0);
        chk("mr_data", data, 0);
        chk("mr_count", count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ovr", ovr, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        send(0, 8'h3C, 1'b0, 2'b11);
        repeat (2) @(negedge clk);
        chk("mr_3c_count", count, 1);
        chk("mr_3c_data", data, 8'h3C);
        chk("mr_3c_perr", perr, 0);
        chk("mr_3c_ferr", ferr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
